// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write port between N_REQ requesters.
// Serialises one AW/W/B transaction at a time, with a B-channel timeout.
module axi_lite_wr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic               rsp_ok,
  output logic               rsp_timeout,
  output logic [7:0]         aw_addr,
  output logic               aw_valid,
  input  logic               aw_ready,
  output logic [31:0]        w_data,
  output logic               w_valid,
  input  logic               w_ready,
  input  logic               b_response,
  input  logic               b_valid,
  output logic               b_ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = 1;
  localparam logic [4:0] T_LAST = 5'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_B,
    RESP
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] last_grant, idx;
  logic [IW-1:0] grant_idx, j;
  logic          grant_any;
  logic [7:0]    addr_q, sel_addr;
  logic [31:0]   data_q, sel_data;
  logic [4:0]    timer;
  logic          aw_done, w_done;
  logic          ok_q, to_q;
  logic          aw_hs, w_hs, expired;

  // Scan from the slot after last_grant; the nearest set bit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    j = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = j;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == grant_idx) begin
        sel_addr = req_addr[i*8 +: 8];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  assign aw_valid = (state == ISSUE) && !aw_done;
  assign w_valid  = (state == ISSUE) && !w_done;
  assign b_ready  = (state == WAIT_B);
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;
  assign expired  = (timer == T_LAST);
  assign aw_addr  = addr_q;
  assign w_data   = data_q;

  assign req_ready = (state == IDLE && grant_any)
                   ? (ONE << grant_idx) : '0;
  assign rsp_valid = (state == RESP) ? (ONE << idx) : '0;
  assign rsp_ok      = (state == RESP) && ok_q;
  assign rsp_timeout = (state == RESP) && to_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (grant_any) state_n = ISSUE;
      // Expiry in ISSUE means no B can have arrived yet.
      ISSUE: begin
        if (expired)
          state_n = RESP;
        else if ((aw_done || aw_hs) && (w_done || w_hs))
          state_n = WAIT_B;
      end
      WAIT_B: if (b_valid || expired) state_n = RESP;
      RESP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      idx        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      timer      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ok_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            addr_q     <= sel_addr;
            data_q     <= sel_data;
            idx        <= grant_idx;
            last_grant <= grant_idx;
            timer      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ok_q       <= 1'b0;
            to_q       <= 1'b0;
          end
        end
        ISSUE: begin
          timer <= timer + 5'd1;
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) w_done <= 1'b1;
          if (expired) to_q <= 1'b1;
        end
        WAIT_B: begin
          timer <= timer + 5'd1;
          if (b_valid) ok_q <= b_response;
          else if (expired) to_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
